// File: rtl/mac_pkg.sv
// rtl/mac_pkg.sv - FP16 field widths, constants and FSM state shared by the MAC datapath
package mac_pkg;

  localparam int EXP_W      = 5;
  localparam int MANT_W     = 10;
  localparam int FP_W       = 16;
  localparam int EXP_BIAS   = 15;
  localparam int EXP_MAX    = 2 * EXP_BIAS;
  localparam int GUARD_BITS = 3;
  localparam int ALIGN_W    = MANT_W + 1 + GUARD_BITS;
  localparam int SUM_W      = ALIGN_W + 1;

  localparam logic [FP_W-1:0] FP16_MAX  = 16'h7BFF;
  localparam logic [FP_W-1:0] FP16_ZERO = 16'h0000;

  typedef enum logic [2:0] {
    IDLE,
    ALIGN,
    ADD,
    NORM,
    DONE
  } mac_state_t;

  // Subnormals flush to +0; Inf/NaN clamp to signed max finite.
  function automatic logic [FP_W-1:0] fp16_sanitize(input logic [FP_W-1:0] x);
    logic [FP_W-1:0] r;
    r = x;
    if (x[FP_W-2 -: EXP_W] == '0) begin
      r = FP16_ZERO;
    end else if (x[FP_W-2 -: EXP_W] == '1) begin
      r = {x[FP_W-1], FP16_MAX[FP_W-2:0]};
    end
    return r;
  endfunction

endpackage

// File: rtl/fp16_lzc.sv
// rtl/fp16_lzc.sv - combinational 15-bit leading-zero counter for normalisation
module fp16_lzc (
  input  logic [14:0] value,
  output logic [3:0]  count
);

  always_comb begin
    count = 4'd15;
    for (int i = 0; i < 15; i++) begin
      if (value[i]) begin
        count = 4'(14 - i);
      end
    end
  end

endmodule

// File: rtl/mac_accumulator.sv
// rtl/mac_accumulator.sv - FP16 dot-product accumulator, one term per four cycles
module mac_accumulator
  import mac_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [15:0] in_data,
  input  logic        in_last,
  output logic        in_ready,
  output logic        out_valid,
  output logic [15:0] out_data,
  output logic [7:0]  out_count,
  input  logic        out_ready
);

  localparam logic signed [6:0] EXP_HI = 7'(EXP_MAX);

  mac_state_t state, state_next;
  logic       started;
  logic       accept;

  logic [FP_W-1:0]    acc, opnd;
  logic               last_q;
  logic [7:0]         term_count;
  logic [ALIGN_W-1:0] ma_q, mb_q;
  logic               sa_q, sb_q;
  logic [EXP_W-1:0]   e_al_q;
  logic [SUM_W-1:0]   sum_q;
  logic               s_sum_q;
  logic [EXP_W-1:0]   e_sum_q;

  assign accept = in_valid && in_ready;

  // started keeps in_ready low until the first edge after reset release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      started <= 1'b0;
    end else begin
      state   <= state_next;
      started <= 1'b1;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = ALIGN;
      ALIGN:   state_next = ADD;
      ADD:     state_next = NORM;
      NORM:    state_next = last_q ? DONE : IDLE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = started && (state == IDLE);
    out_valid = (state == DONE);
    out_data  = acc;
    out_count = term_count;
  end

  logic [EXP_W-1:0]   ea, eb, ediff, e_al_d;
  logic [ALIGN_W-1:0] ma_full, mb_full, ma_d, mb_d;
  logic               a_big;

  always_comb begin
    ea      = acc[FP_W-2 -: EXP_W];
    eb      = opnd[FP_W-2 -: EXP_W];
    ma_full = (ea == '0) ? '0 : {1'b1, acc[MANT_W-1:0], {GUARD_BITS{1'b0}}};
    mb_full = (eb == '0) ? '0 : {1'b1, opnd[MANT_W-1:0], {GUARD_BITS{1'b0}}};
    a_big   = (ea >= eb);
    ediff   = a_big ? (ea - eb) : (eb - ea);
    ma_d    = ma_full;
    mb_d    = mb_full;
    e_al_d  = a_big ? ea : eb;
    if (a_big) begin
      mb_d = (ediff >= 5'(ALIGN_W)) ? '0 : (mb_full >> ediff);
    end else begin
      ma_d = (ediff >= 5'(ALIGN_W)) ? '0 : (ma_full >> ediff);
    end
  end

  logic [SUM_W-1:0] sum_d;
  logic             s_sum_d;

  always_comb begin
    sum_d   = '0;
    s_sum_d = 1'b0;
    if (sa_q == sb_q) begin
      sum_d   = {1'b0, ma_q} + {1'b0, mb_q};
      s_sum_d = sa_q;
    end else if (ma_q > mb_q) begin
      sum_d   = {1'b0, ma_q} - {1'b0, mb_q};
      s_sum_d = sa_q;
    end else if (mb_q > ma_q) begin
      sum_d   = {1'b0, mb_q} - {1'b0, ma_q};
      s_sum_d = sb_q;
    end
  end

  logic [3:0]        lz, lz_m1;
  logic [SUM_W-1:0]  norm;
  logic signed [6:0] e_res;
  logic [FP_W-1:0]   res;
  logic              norm_unused;

  fp16_lzc u_lzc (
    .value (sum_q),
    .count (lz)
  );

  // The hidden bit belongs at bit ALIGN_W-1, one below the carry position
  always_comb begin
    lz_m1 = lz - 4'd1;
    norm  = sum_q;
    e_res = $signed({2'b00, e_sum_q});
    res   = FP16_ZERO;
    if (sum_q != '0) begin
      if (sum_q[SUM_W-1]) begin
        norm  = sum_q >> 1;
        e_res = $signed({2'b00, e_sum_q}) + 7'sd1;
      end else begin
        norm  = sum_q << lz_m1;
        e_res = $signed({2'b00, e_sum_q}) - $signed({3'b000, lz_m1});
      end
      if (e_res > EXP_HI) begin
        res = {s_sum_q, FP16_MAX[FP_W-2:0]};
      end else if (e_res < 7'sd1) begin
        res = FP16_ZERO;
      end else begin
        res = {s_sum_q, e_res[EXP_W-1:0], norm[ALIGN_W-2 -: MANT_W]};
      end
    end
  end

  assign norm_unused = ^{norm[SUM_W-1:ALIGN_W-1], norm[GUARD_BITS-1:0], e_res[6:5]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc        <= FP16_ZERO;
      opnd       <= FP16_ZERO;
      last_q     <= 1'b0;
      term_count <= 8'd0;
      ma_q       <= '0;
      mb_q       <= '0;
      sa_q       <= 1'b0;
      sb_q       <= 1'b0;
      e_al_q     <= '0;
      sum_q      <= '0;
      s_sum_q    <= 1'b0;
      e_sum_q    <= '0;
    end else begin
      if (accept) begin
        opnd   <= fp16_sanitize(in_data);
        last_q <= in_last;
      end
      if (state == ALIGN) begin
        ma_q   <= ma_d;
        mb_q   <= mb_d;
        sa_q   <= acc[FP_W-1];
        sb_q   <= opnd[FP_W-1];
        e_al_q <= e_al_d;
      end
      if (state == ADD) begin
        sum_q   <= sum_d;
        s_sum_q <= s_sum_d;
        e_sum_q <= e_al_q;
      end
      if (state == NORM) begin
        acc        <= res;
        term_count <= (term_count == 8'hFF) ? term_count : term_count + 8'd1;
      end
      if ((state == DONE) && out_ready) begin
        acc        <= FP16_ZERO;
        term_count <= 8'd0;
      end
    end
  end

endmodule

// File: doc/mac_accumulator.md
MAC_ACCUMULATOR -- requirements
Module: mac_accumulator

Interface
REQ-001 The block SHALL have the port clk, input, 1 bit: the single clock, with all state updating on the rising edge.
REQ-002 The block SHALL have the port rst_n, input, 1 bit: the reset, which is asynchronous and active-low.
REQ-003 The block SHALL have the port in_valid, input, 1 bit: an FP16 product from the multiplier stage is present.
REQ-004 The block SHALL have the port in_data, input, 16 bits: the FP16 product, as sign[15], exponent[14:10] with bias 15, mantissa[9:0].
REQ-005 The block SHALL have the port in_last, input, 1 bit: the current product is the final term of the dot product.
REQ-006 The block SHALL have the port in_ready, output, 1 bit: the block accepts a product this cycle.
REQ-007 The block SHALL have the port out_valid, output, 1 bit: the accumulated result is available.
REQ-008 The block SHALL have the port out_data, output, 16 bits: the FP16 accumulated sum.
REQ-009 The block SHALL have the port out_count, output, 8 bits: the number of terms accumulated, saturating at 255.
REQ-010 The block SHALL have the port out_ready, input, 1 bit: downstream accepts the result.

Function
REQ-011 The block SHALL transfer an input only on a rising edge where in_valid=1 and in_ready=1.
REQ-012 The block SHALL use the FSM states IDLE, ALIGN, ADD, NORM and DONE.
REQ-013 In IDLE, in_ready SHALL be 1; in every other state, in_ready SHALL be 0.
REQ-014 The FSM SHALL move IDLE->ALIGN on acceptance, then ALIGN->ADD->NORM unconditionally.
REQ-015 From NORM, the FSM SHALL go to DONE if the captured in_last=1, and to IDLE otherwise.
REQ-016 The accumulator register and out_count SHALL update on the NORM->next edge, giving one accepted term per 4 cycles.
REQ-017 ALIGN SHALL expand both operands to an 11-bit mantissa with the hidden 1 and 3 guard bits.
REQ-018 ALIGN SHALL right-shift the smaller-exponent operand by the exponent difference; a difference of 14 or more SHALL make that operand contribute zero.
REQ-019 ADD SHALL add the magnitudes when the signs are equal; otherwise it SHALL subtract the smaller magnitude from the larger and take the sign of the larger.
REQ-020 A result with equal magnitudes and opposite signs SHALL be +0 (0x0000).
REQ-021 On a carry-out, NORM SHALL shift right by 1 and add 1 to the exponent.
REQ-022 Otherwise, NORM SHALL shift left by the leading-zero count and subtract that count from the exponent.
REQ-023 Rounding SHALL be truncation, discarding the guard bits.
REQ-024 An input with exponent 0 (zero or subnormal) SHALL be treated as +0 (flush to zero).
REQ-025 An input with exponent 31 SHALL be treated as ±0x7BFF (max finite), keeping its sign.
REQ-026 A result exponent greater than 30 SHALL saturate to ±0x7BFF.
REQ-027 A result exponent less than 1 SHALL flush to 0x0000.
REQ-028 In DONE, out_valid SHALL be 1, and out_data and out_count SHALL be held stable until out_ready=1.
REQ-029 On the edge where DONE and out_ready=1, the FSM SHALL go to IDLE, the accumulator SHALL become 0x0000, out_count SHALL become 0, and out_valid SHALL fall.
REQ-030 Outside DONE, out_valid SHALL be 0 and out_data SHALL show the running accumulator.
REQ-031 in_valid and in_data SHALL be ignored in every state other than IDLE.
REQ-032 out_count SHALL saturate at 255 and never wrap.
REQ-033 Latency SHALL be: last term accepted on edge N -> out_valid=1 from edge N+3.

Reset
REQ-034 While rst_n=0, the block SHALL be in IDLE with accumulator=0x0000, out_data=0x0000, out_count=0, out_valid=0 and in_ready=0, asserted asynchronously.
REQ-035 Reset SHALL abort any in-flight term with no partial update retained.
REQ-036 in_ready SHALL rise on the first clock edge after rst_n deasserts.

Structure
REQ-037 Package mac_pkg SHALL hold FP16 field widths, EXP_BIAS=15, FP16_MAX=16'h7BFF, FP16_ZERO, GUARD_BITS=3 and the FSM state enum, shared with the multiplier stage.
REQ-038 The block SHALL contain one sub-module, fp16_lzc: a combinational 15-bit leading-zero counter used by NORM.

Verification
REQ-039 The bench SHALL check: 0x3C00 then 0x3C00 with in_last -> out_data=0x4000, out_count=2, out_valid 3 edges after the second accept.
REQ-040 The bench SHALL check: 0x3E00 then 0x3E00 with in_last -> out_data=0x4200 (1.5+1.5=3.0).
REQ-041 The bench SHALL check: 0x3C00 then 0xBC00 with in_last -> out_data=0x0000; and 0x7BFF then 0x7BFF -> 0x7BFF (saturation).
REQ-042 The bench SHALL check: 0x3C00 then 0x1000 with in_last -> out_data=0x3C00 (small term truncated away); and 0x0001 then 0x3C00 -> 0x3C00 (subnormal flushed).
REQ-043 The bench SHALL check: out_ready held 0 for 5 cycles in DONE, with in_valid=1 -> out_data and out_count stable, in_ready=0, no input consumed.
REQ-044 The bench SHALL check: rst_n pulsed low during ADD -> all outputs are zero before the next edge, and the next accepted 0x3C00 with in_last yields 0x3C00 with count 1.
